// File: rtl/rv32i_test_mon_pkg.sv
// Shared types and default constants for the RV32I test-run monitor.
package rv32i_test_mon_pkg;

  localparam int unsigned RST_CYCLES_DEF     = 10;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000;
  localparam int unsigned CNT_W_DEF          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  function automatic logic is_terminal(input state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/rv32i_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module rv32i_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rv32i_test_monitor.sv
// Sequences core reset, watches for the ECALL/gp pass-fail convention and a run timeout.
// Define RV32I_TEST_MON_STATS_EN to build the cumulative pass/fail/timeout tallies.
module rv32i_test_monitor
  import rv32i_test_mon_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = RST_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_ecall,
  input  logic [31:0]      gp_value,
  output logic             core_rst_n,
  output logic             busy,
  output logic             done,
  output logic             done_pulse,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_testnum,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned     RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e         state;
  state_e         next_state;
  logic [RCW-1:0] rst_cnt;
  logic           enter_pass;
  logic           enter_fail;
  logic           enter_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Ecall outranks timeout; start outranks everything.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESET: if (rst_cnt == RST_LAST) next_state = ST_RUN;
      ST_RUN: begin
        if (is_ecall)                   next_state = (gp_value == 32'h1) ? ST_PASS : ST_FAIL;
        else if (cycle_count == TO_LAST) next_state = ST_TIMEOUT;
      end
      default: next_state = state;
    endcase
    if (start) next_state = ST_RESET;
  end

  assign enter_pass = (state == ST_RUN) && (next_state == ST_PASS);
  assign enter_fail = (state == ST_RUN) && (next_state == ST_FAIL);
  assign enter_to   = (state == ST_RUN) && (next_state == ST_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             rst_cnt <= '0;
    else if ((state == ST_RESET) && !start) rst_cnt <= rst_cnt + RCW'(1);
    else                                    rst_cnt <= '0;
  end

  // Status flops track the upcoming state so they line up with it cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_pulse   <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      core_rst_n <= (next_state != ST_IDLE) && (next_state != ST_RESET);
      busy       <= (next_state == ST_RESET) || (next_state == ST_RUN);
      done       <= is_terminal(next_state);
      done_pulse <= enter_pass || enter_fail || enter_to;
      pass       <= (next_state == ST_PASS);
      fail       <= (next_state == ST_FAIL);
      timeout    <= (next_state == ST_TIMEOUT);
      if (start)           fail_testnum <= '0;
      else if (enter_fail) fail_testnum <= gp_value[31:1];
    end
  end

  // Counts only cycles that stay in RUN, so the value freezes on the deciding cycle.
  rv32i_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   ((state == ST_RUN) && (next_state == ST_RUN)),
    .count (cycle_count)
  );

`ifdef RV32I_TEST_MON_STATS_EN
  rv32i_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (enter_pass),
    .count (pass_cnt)
  );

  rv32i_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (enter_fail),
    .count (fail_cnt)
  );

  rv32i_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (enter_to),
    .count (timeout_cnt)
  );
`else
  assign pass_cnt    = '0;
  assign fail_cnt    = '0;
  assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_rv32i_test_monitor.sv
// Self-checking bench for rv32i_test_monitor: timestamp-based reference model plus directed and random runs.
module tb_rv32i_test_monitor;

  localparam int unsigned RST   = 10;
  localparam int unsigned TO    = 5000;
  localparam int unsigned CW    = 16;
  localparam int unsigned SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          is_ecall;
  logic [31:0]   gp_value;
  logic          core_rst_n, busy, done, done_pulse, pass, fail, timeout;
  logic [30:0]   fail_testnum;
  logic [CW-1:0] cycle_count, pass_cnt, fail_cnt, timeout_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  rv32i_test_monitor #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_ecall     (is_ecall),
    .gp_value     (gp_value),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .done_pulse   (done_pulse),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a run is described by when it started and how/when it ended.
  int          cyc = 0;
  bit          started = 1'b0;
  int          st_cyc = 0;
  int          term = 0;          // 0 none, 1 pass, 2 fail, 3 timeout
  int          term_cyc = 0;
  int          rc_final = 0;
  logic [30:0] m_tn = '0;
  int          m_pc = 0, m_fc = 0, m_tc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started = 1'b0; term = 0; m_tn = '0; m_pc = 0; m_fc = 0; m_tc = 0;
    end else begin
      cyc++;
      if (start) begin
        started = 1'b1; st_cyc = cyc; term = 0; m_tn = '0;
      end else if (started && term == 0 && (cyc - st_cyc) >= int'(RST) + 1) begin
        int ri;
        ri = cyc - st_cyc - int'(RST) - 1;
        if (ri > int'(SAT)) ri = int'(SAT);
        if (is_ecall) begin
          term_cyc = cyc; rc_final = ri;
          if (gp_value == 32'h1) begin term = 1; if (m_pc < int'(SAT)) m_pc++; end
          else begin term = 2; m_tn = gp_value[31:1]; if (m_fc < int'(SAT)) m_fc++; end
        end else if (ri == int'(TO) - 1) begin
          term = 3; term_cyc = cyc; rc_final = ri;
          if (m_tc < int'(SAT)) m_tc++;
        end
      end
    end
  end

  function automatic int m_cc();
    int k;
    k = cyc - st_cyc;
    if (!started) return 0;
    if (term != 0) return rc_final;
    if (k < int'(RST)) return 0;
    return ((k - int'(RST)) > int'(SAT)) ? int'(SAT) : (k - int'(RST));
  endfunction

  function automatic bit m_run_at(input int n);
    return started && term == 0 && (cyc - st_cyc) >= int'(RST) && (cyc - st_cyc - int'(RST)) == n;
  endfunction

  // Every-cycle comparison against the model, sampled after the edge settles.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      bit in_run, in_rst;
      in_rst = started && term == 0 && (cyc - st_cyc) < int'(RST);
      in_run = started && term == 0 && !in_rst;
      chk("core_rst_n", 64'(core_rst_n), 64'(started && !in_rst));
      chk("busy",       64'(busy),       64'(in_rst || in_run));
      chk("done",       64'(done),       64'(started && term != 0));
      chk("done_pulse", 64'(done_pulse), 64'(started && term != 0 && term_cyc == cyc));
      chk("pass",       64'(pass),       64'(started && term == 1));
      chk("fail",       64'(fail),       64'(started && term == 2));
      chk("timeout",    64'(timeout),    64'(started && term == 3));
      chk("fail_testnum", 64'(fail_testnum), 64'(m_tn));
      chk("cycle_count",  64'(cycle_count),  64'(m_cc()));
`ifdef RV32I_TEST_MON_STATS_EN
      chk("pass_cnt",    64'(pass_cnt),    64'(m_pc));
      chk("fail_cnt",    64'(fail_cnt),    64'(m_fc));
      chk("timeout_cnt", 64'(timeout_cnt), 64'(m_tc));
`else
      chk("pass_cnt",    64'(pass_cnt),    64'd0);
      chk("fail_cnt",    64'(fail_cnt),    64'd0);
      chk("timeout_cnt", 64'(timeout_cnt), 64'd0);
`endif
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic ecall_at(input int n, input logic [31:0] gv);
    int w = 0;
    while (!m_run_at(n) && w < 6000) begin @(negedge clk); w++; end
    if (!m_run_at(n)) begin
      checks++; errors++;
      $display("FAIL ecall_wait: run cycle %0d never reached", n);
      return;
    end
    is_ecall = 1'b1; gp_value = gv;
    @(negedge clk);
    is_ecall = 1'b0; gp_value = $urandom;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 6000) begin @(negedge clk); w++; end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  logic [CW-1:0] exp_pc2;

  initial begin
    rst_n = 1'b1; start = 1'b0; is_ecall = 1'b0; gp_value = 32'h0;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ecall while idle is ignored.
    is_ecall = 1'b1; gp_value = 32'h1;
    @(negedge clk); is_ecall = 1'b0;
    chk("idle_ecall_done", 64'(done), 64'd0);

    // Core reset held for exactly RST cycles.
    do_start();
    for (int i = 1; i < int'(RST); i++) begin
      @(negedge clk);
      chk("reset_hold", 64'(core_rst_n), 64'd0);
    end
    @(negedge clk);
    chk("reset_release", 64'(core_rst_n), 64'd1);
    chk("run_busy", 64'(busy), 64'd1);

    // Pass at run cycle 100.
    ecall_at(100, 32'h1);
    chk("pass100_pass", 64'(pass), 64'd1);
    chk("pass100_pulse", 64'(done_pulse), 64'd1);
    chk("pass100_cc", 64'(cycle_count), 64'd100);
    repeat (5) @(negedge clk);
    chk("pass100_pulse_gone", 64'(done_pulse), 64'd0);
    chk("pass100_hold_cc", 64'(cycle_count), 64'd100);

    // Fail with gp=7 gives test number 3.
    do_start();
    ecall_at(20, 32'h7);
    chk("fail7_fail", 64'(fail), 64'd1);
    chk("fail7_testnum", 64'(fail_testnum), 64'd3);
`ifdef RV32I_TEST_MON_STATS_EN
    chk("fail7_fail_cnt", 64'(fail_cnt), 64'd1);
`endif

    // Timeout with no ecall.
    do_start();
    wait_done();
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_cc", 64'(cycle_count), 64'd4999);
    chk("to_busy", 64'(busy), 64'd0);

    // Ecall on the timeout cycle wins.
    do_start();
    ecall_at(4999, 32'h1);
    chk("edge_pass", 64'(pass), 64'd1);
    chk("edge_timeout", 64'(timeout), 64'd0);

    // Restart from PASS clears status but keeps tallies.
    do_start();
    chk("restart_pass", 64'(pass), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
`ifdef RV32I_TEST_MON_STATS_EN
    exp_pc2 = CW'(2);
`else
    exp_pc2 = '0;
`endif
    chk("restart_pass_cnt", 64'(pass_cnt), 64'(exp_pc2));

    // Asynchronous reset in the middle of a run.
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("midrun_cc", 64'(cycle_count), 64'd0);
    chk("midrun_busy", 64'(busy), 64'd0);
    chk("midrun_pass_cnt", 64'(pass_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: starts, ecalls with random gp, occasional resets.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!rst_n)                              rst_n = 1'b1;
      else if ($urandom_range(0, 1499) == 0)   rst_n = 1'b0;
      if (!started || term != 0) start = ($urandom_range(0, 7) == 0);
      else                       start = ($urandom_range(0, 299) == 0);
      is_ecall = ($urandom_range(0, 59) == 0);
      gp_value = ($urandom_range(0, 2) == 0) ? $urandom : 32'h1;
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; is_ecall = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_test_monitor.md
RV32I_TEST_MONITOR -- requirements
Module: rv32i_test_monitor

Interface
REQ-001 Parameter RST_CYCLES, default 10: number of clk cycles core_rst_n is held low after start.
REQ-002 Parameter TIMEOUT_CYCLES, default 5000: run cycles allowed before TIMEOUT is declared.
REQ-003 Parameter CNT_W, default 16: width of cycle and statistics counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle pulse; begins (or restarts) a test run.
REQ-007 is_ecall  input  1  core retiring an ECALL this cycle.
REQ-008 gp_value  input  32  current core register x3 (gp).
REQ-009 core_rst_n  output  1  active-low reset driven to the core.
REQ-010 busy  output  1  high in RESET or RUN.
REQ-011 done  output  1  high in PASS, FAIL or TIMEOUT.
REQ-012 done_pulse  output  1  one-cycle pulse on entry to any terminal state.
REQ-013 pass / fail / timeout  output  1 each  one-hot terminal status.
REQ-014 fail_testnum  output  31  gp_value[31:1] captured on FAIL.
REQ-015 cycle_count  output  CNT_W  RUN cycles elapsed in the current/last test.
REQ-016 pass_cnt / fail_cnt / timeout_cnt  output  CNT_W each  cumulative tallies.

Function
REQ-017 FSM states SHALL be IDLE, RESET, RUN, PASS, FAIL, TIMEOUT.
REQ-018 start in any state SHALL go to RESET, clear cycle_count, fail_testnum, pass, fail, timeout; start has priority over all other events.
REQ-019 RESET SHALL hold core_rst_n low for exactly RST_CYCLES cycles, then go to RUN.
REQ-020 core_rst_n SHALL be low in IDLE and RESET, high in RUN, PASS, FAIL, TIMEOUT.
REQ-021 In RUN, cycle_count SHALL increment by 1 per cycle, saturating at all-ones.
REQ-022 In RUN, is_ecall=1 with gp_value==32'h1 SHALL go to PASS next cycle.
REQ-023 In RUN, is_ecall=1 with gp_value!=32'h1 SHALL go to FAIL next cycle and capture gp_value[31:1] into fail_testnum.
REQ-024 In RUN, without ecall, cycle_count==TIMEOUT_CYCLES-1 SHALL go to TIMEOUT next cycle.
REQ-025 Ecall and timeout in the same cycle: ecall SHALL win.
REQ-026 is_ecall SHALL be ignored in IDLE, RESET and terminal states.
REQ-027 Terminal states SHALL hold, with status outputs stable, until start or rst_n.
REQ-028 Latency: ecall sampled at edge N SHALL be visible on done/pass/fail after edge N (one cycle).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, core_rst_n=0, and all other outputs and counters to 0, including mid-RESET or mid-RUN.

Configuration
REQ-030 With RV32I_TEST_MON_STATS_EN defined, pass_cnt/fail_cnt/timeout_cnt SHALL increment by 1, saturating, on entry to the matching terminal state; they are cleared only by rst_n, never by start.
REQ-031 Without RV32I_TEST_MON_STATS_EN, the counter ports SHALL remain present and be tied to 0, with no counter flops.

Structure
REQ-032 Package rv32i_test_mon_pkg SHALL hold the state enum and the default RST_CYCLES/TIMEOUT_CYCLES constants.
REQ-033 A sub-module rv32i_sat_counter (clear, increment, saturating, CNT_W) SHALL implement cycle_count and the statistics counters.

Verification
REQ-034 Reset release, start at cycle 0 -> core_rst_n low for exactly 10 cycles, then high, busy=1.
REQ-035 RUN, is_ecall=1 with gp_value=1 at run cycle 100 -> pass=1, done_pulse for 1 cycle, cycle_count=100 held.
REQ-036 is_ecall=1 with gp_value=32'h7 -> fail=1, fail_testnum=3; with STATS_EN, fail_cnt=1.
REQ-037 No ecall -> timeout=1 once cycle_count reaches 4999; ecall at that same cycle -> pass/fail instead.
REQ-038 rst_n low mid-RUN -> IDLE, core_rst_n=0, counters 0; start during PASS -> RESET, status cleared, pass_cnt retained.
